pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_ctrl_pkg.sv | 25 ++
 rtl/fwd_select.sv | 38 +++
 rtl/pipeline_hazard_controller.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// controller states, forward-select encodings and saturating counter helper.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH2     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10,
    FWD_RET = 2'b11
  } fwd_sel_t;

  localparam logic [3:0]  REG_PC  = 4'd15;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-source producer match and forward select for one decode-stage operand.
// The youngest in-flight producer wins; r15 (PC) is never forwarded.
module fwd_select
  import pipeline_ctrl_pkg::*;
(
  input  logic       src_used,
  input  logic [3:0] src,
  input  logic       ex_valid,
  input  logic       ex_wr,
  input  logic [3:0] ex_rd,
  input  logic       mem_valid,
  input  logic       mem_wr,
  input  logic [3:0] mem_rd,
  input  logic       wb_valid,
  input  logic       wb_wr,
  input  logic [3:0] wb_rd,
  output logic       ex_match,
  output fwd_sel_t   sel
);

  logic src_ok;
  logic mem_match;
  logic wb_match;

  assign src_ok    = src_used && (src != REG_PC);
  assign ex_match  = src_ok && ex_valid  && ex_wr  && (ex_rd  == src);
  assign mem_match = src_ok && mem_valid && mem_wr && (mem_rd == src);
  assign wb_match  = src_ok && wb_valid  && wb_wr  && (wb_rd  == src);

  // Select names where the producer will sit once this operand reaches execute.
  always_comb begin
    sel = FWD_RF;
    if (ex_match)       sel = FWD_MEM;
    else if (mem_match) sel = FWD_WB;
    else if (wb_match)  sel = FWD_RET;
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Load-use stall, taken-branch flush and operand-forwarding control for a
// five-stage pipeline, with saturating stall/flush performance counters.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [3:0]  dec_rn,
  input  logic [3:0]  dec_rm,
  input  logic [3:0]  dec_rs,
  input  logic [2:0]  dec_use,
  input  logic        ex_valid,
  input  logic [3:0]  ex_rd,
  input  logic        ex_wr,
  input  logic        ex_is_load,
  input  logic        ex_br_taken,
  input  logic        mem_valid,
  input  logic [3:0]  mem_rd,
  input  logic        mem_wr,
  input  logic        wb_valid,
  input  logic [3:0]  wb_rd,
  input  logic        wb_wr,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        bubble_ex,
  output logic        flush,
  output logic [1:0]  fwd_rn,
  output logic [1:0]  fwd_rm,
  output logic [1:0]  fwd_rs,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  state_t   state, state_next;
  fwd_sel_t sel_rn, sel_rm, sel_rs;
  fwd_sel_t fwd_rn_q, fwd_rm_q, fwd_rs_q;
  logic     ex_match_rn, ex_match_rm, ex_match_rs;
  logic     load_use;

  fwd_select u_fwd_rn (
    .src_used (dec_use[0]), .src (dec_rn),
    .ex_valid (ex_valid),   .ex_wr (ex_wr),   .ex_rd (ex_rd),
    .mem_valid(mem_valid),  .mem_wr(mem_wr),  .mem_rd(mem_rd),
    .wb_valid (wb_valid),   .wb_wr (wb_wr),   .wb_rd (wb_rd),
    .ex_match (ex_match_rn), .sel (sel_rn)
  );

  fwd_select u_fwd_rm (
    .src_used (dec_use[1]), .src (dec_rm),
    .ex_valid (ex_valid),   .ex_wr (ex_wr),   .ex_rd (ex_rd),
    .mem_valid(mem_valid),  .mem_wr(mem_wr),  .mem_rd(mem_rd),
    .wb_valid (wb_valid),   .wb_wr (wb_wr),   .wb_rd (wb_rd),
    .ex_match (ex_match_rm), .sel (sel_rm)
  );

  fwd_select u_fwd_rs (
    .src_used (dec_use[2]), .src (dec_rs),
    .ex_valid (ex_valid),   .ex_wr (ex_wr),   .ex_rd (ex_rd),
    .mem_valid(mem_valid),  .mem_wr(mem_wr),  .mem_rd(mem_rd),
    .wb_valid (wb_valid),   .wb_wr (wb_wr),   .wb_rd (wb_rd),
    .ex_match (ex_match_rs), .sel (sel_rs)
  );

  assign load_use = dec_valid && ex_is_load &&
                    (ex_match_rn || ex_match_rm || ex_match_rs);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Outputs are held low while reset is asserted so an aborted flush leaves nothing behind.
  always_comb begin
    state_next   = state;
    stall_fetch  = 1'b0;
    stall_decode = 1'b0;
    bubble_ex    = 1'b0;
    flush        = 1'b0;
    if (rst_n) begin
      case (state)
        RUN, LOAD_STALL: begin
          state_next = RUN;
          if (ex_br_taken) begin
            flush      = 1'b1;
            bubble_ex  = 1'b1;
            state_next = FLUSH2;
          end else if ((state == RUN) && load_use) begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            bubble_ex    = 1'b1;
            state_next   = LOAD_STALL;
          end
        end
        FLUSH2: begin
          flush      = 1'b1;
          bubble_ex  = 1'b1;
          state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bubble_ex) begin
      fwd_rn_q <= FWD_RF;
      fwd_rm_q <= FWD_RF;
      fwd_rs_q <= FWD_RF;
    end else if (!stall_decode) begin
      fwd_rn_q <= sel_rn;
      fwd_rm_q <= sel_rm;
      fwd_rs_q <= sel_rs;
    end
  end

  assign fwd_rn = fwd_rn_q;
  assign fwd_rm = fwd_rm_q;
  assign fwd_rs = fwd_rs_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_decode) stall_cnt <= sat_inc(stall_cnt);
      if (flush)        flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller: load-use stalls,
// branch flushes, forward selection, reset abort and counter saturation.
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid;
  logic [3:0]  dec_rn, dec_rm, dec_rs;
  logic [2:0]  dec_use;
  logic        ex_valid, ex_wr, ex_is_load, ex_br_taken;
  logic [3:0]  ex_rd;
  logic        mem_valid, mem_wr;
  logic [3:0]  mem_rd;
  logic        wb_valid, wb_wr;
  logic [3:0]  wb_rd;
  logic        stall_fetch, stall_decode, bubble_ex, flush;
  logic [1:0]  fwd_rn, fwd_rm, fwd_rs;
  logic [15:0] stall_cnt, flush_cnt;

  int compared   = 0;
  int mismatched = 0;

  pipeline_hazard_controller dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_rn(dec_rn), .dec_rm(dec_rm), .dec_rs(dec_rs),
    .dec_use(dec_use),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
    .ex_br_taken(ex_br_taken),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wr(wb_wr),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .bubble_ex(bubble_ex), .flush(flush),
    .fwd_rn(fwd_rn), .fwd_rm(fwd_rm), .fwd_rs(fwd_rs),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    dec_valid = 0; dec_rn = 0; dec_rm = 0; dec_rs = 0; dec_use = 0;
    ex_valid = 0; ex_rd = 0; ex_wr = 0; ex_is_load = 0; ex_br_taken = 0;
    mem_valid = 0; mem_rd = 0; mem_wr = 0;
    wb_valid = 0; wb_rd = 0; wb_wr = 0;
  endtask

  task automatic setLoadUseR3();
    ex_valid = 1; ex_rd = 4'd3; ex_wr = 1; ex_is_load = 1;
    dec_valid = 1; dec_rn = 4'd3; dec_use = 3'b001;
  endtask

  // {stall_fetch, stall_decode, bubble_ex, flush}
  function automatic logic [31:0] ctl();
    return {28'd0, stall_fetch, stall_decode, bubble_ex, flush};
  endfunction

  initial begin
    clearInputs();
    rst_n = 0;
    applyStimulus(2);
    checkOutput("reset_ctl", ctl(), 32'h0);
    checkOutput("reset_fwd", {26'd0, fwd_rn, fwd_rm, fwd_rs}, 32'h0);
    checkOutput("reset_stall_cnt", stall_cnt, 32'h0);
    checkOutput("reset_flush_cnt", flush_cnt, 32'h0);
    rst_n = 1;
    applyStimulus(1);
    checkOutput("idle_ctl", ctl(), 32'h0);

    // Load r3 in execute, decode reads r3
    setLoadUseR3();
    #1 checkOutput("loaduse_ctl", ctl(), 32'hE);
    applyStimulus(1);
    ex_valid = 0; ex_is_load = 0; ex_wr = 0;
    mem_valid = 1; mem_rd = 4'd3; mem_wr = 1;
    #1 checkOutput("loadstall_ctl", ctl(), 32'h0);
    checkOutput("loaduse_fwd_bubble", fwd_rn, 32'h0);
    checkOutput("loaduse_stall_cnt", stall_cnt, 32'h1);
    applyStimulus(1);
    checkOutput("loaduse_fwd_rn", fwd_rn, 32'h2);
    checkOutput("loaduse_stall_cnt2", stall_cnt, 32'h1);

    // Invalid decode never stalls
    clearInputs();
    setLoadUseR3();
    dec_valid = 0;
    #1 checkOutput("decinvalid_ctl", ctl(), 32'h0);
    applyStimulus(1);
    checkOutput("decinvalid_stall_cnt", stall_cnt, 32'h1);

    // Taken branch with simultaneous load-use: two flush cycles, no stall
    clearInputs();
    setLoadUseR3();
    ex_br_taken = 1;
    #1 checkOutput("branch_ctl1", ctl(), 32'h3);
    applyStimulus(1);
    checkOutput("branch_ctl2", ctl(), 32'h3);
    checkOutput("branch_flush_cnt1", flush_cnt, 32'h1);
    applyStimulus(1);
    clearInputs();
    #1 checkOutput("branch_done_ctl", ctl(), 32'h0);
    checkOutput("branch_flush_cnt2", flush_cnt, 32'h2);
    checkOutput("branch_stall_cnt", stall_cnt, 32'h1);
    checkOutput("branch_fwd_rn", fwd_rn, 32'h0);

    // rm=r5: execute ALU and writeback both produce r5
    dec_valid = 1; dec_rm = 4'd5; dec_use = 3'b010;
    ex_valid = 1; ex_rd = 4'd5; ex_wr = 1;
    wb_valid = 1; wb_rd = 4'd5; wb_wr = 1;
    applyStimulus(1);
    checkOutput("fwd_rm_ex_wb", fwd_rm, 32'h1);
    checkOutput("alu_no_stall", ctl(), 32'h0);
    ex_valid = 0;
    applyStimulus(1);
    checkOutput("fwd_rm_wb_only", fwd_rm, 32'h3);
    mem_valid = 1; mem_rd = 4'd5; mem_wr = 1;
    applyStimulus(1);
    checkOutput("fwd_rm_mem_wb", fwd_rm, 32'h2);
    ex_valid = 1; ex_wr = 0;
    mem_valid = 0;
    applyStimulus(1);
    checkOutput("fwd_rm_ex_nowrite", fwd_rm, 32'h3);
    dec_use = 3'b001; dec_rn = 4'd2;
    applyStimulus(1);
    checkOutput("fwd_rm_unused", fwd_rm, 32'h0);
    clearInputs();
    dec_valid = 1; dec_rs = 4'd7; dec_use = 3'b100;
    mem_valid = 1; mem_rd = 4'd7; mem_wr = 1;
    applyStimulus(1);
    checkOutput("fwd_rs_mem", fwd_rs, 32'h2);

    // r15 never matches
    clearInputs();
    ex_valid = 1; ex_rd = 4'd15; ex_wr = 1; ex_is_load = 1;
    dec_valid = 1; dec_rn = 4'd15; dec_use = 3'b001;
    #1 checkOutput("r15_ctl", ctl(), 32'h0);
    applyStimulus(1);
    checkOutput("r15_fwd_rn", fwd_rn, 32'h0);
    checkOutput("r15_stall_cnt", stall_cnt, 32'h1);

    // Taken branch while in LOAD_STALL
    clearInputs();
    setLoadUseR3();
    applyStimulus(1);
    checkOutput("ls_stall_cnt", stall_cnt, 32'h2);
    ex_br_taken = 1;
    #1 checkOutput("ls_branch_ctl", ctl(), 32'h3);
    applyStimulus(1);
    checkOutput("ls_branch_flush2_ctl", ctl(), 32'h3);
    checkOutput("ls_branch_flush_cnt", flush_cnt, 32'h3);

    // Reset asserted in FLUSH2 aborts it
    clearInputs();
    rst_n = 0;
    #1 checkOutput("rst_in_flush2_ctl", ctl(), 32'h0);
    applyStimulus(1);
    checkOutput("rst_stall_cnt", stall_cnt, 32'h0);
    checkOutput("rst_flush_cnt", flush_cnt, 32'h0);
    rst_n = 1;
    setLoadUseR3();
    #1 checkOutput("post_rst_run_ctl", ctl(), 32'hE);
    applyStimulus(1);
    checkOutput("post_rst_stall_cnt", stall_cnt, 32'h1);
    applyStimulus(4);
    checkOutput("alt_stall_cnt", stall_cnt, 32'h3);

    // Continuous taken branches flush every cycle; counter must saturate
    clearInputs();
    ex_br_taken = 1;
    applyStimulus(65540);
    checkOutput("flush_cnt_sat", flush_cnt, 32'hFFFF);
    applyStimulus(20);
    checkOutput("flush_cnt_hold", flush_cnt, 32'hFFFF);
    checkOutput("sat_stall_cnt", stall_cnt, 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
